// File: rtl/cim_pkg.sv
// Shared types and constants for the compute-in-memory array controller.
package cim_pkg;

  localparam int FUNC_W  = 4;
  localparam int ACC_EXT = 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HOST,
    S_CIM_RUN,
    S_CIM_WAIT,
    S_DONE
  } state_e;

  typedef enum logic {
    REQ_HOST = 1'b0,
    REQ_CIM  = 1'b1
  } req_e;

endpackage

// File: rtl/cim_arb.sv
// Two-requester round-robin arbiter; on a collision the requester not served last wins.
module cim_arb
  import cim_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic en_i,
  input  logic req_host_i,
  input  logic req_cim_i,
  output logic gnt_host_o,
  output logic gnt_cim_o
);

  req_e last_q, last_d;

  always_comb begin
    gnt_host_o = 1'b0;
    gnt_cim_o  = 1'b0;
    last_d     = last_q;
    if (en_i) begin
      if (req_host_i && req_cim_i) begin
        gnt_host_o = (last_q == REQ_CIM);
        gnt_cim_o  = (last_q == REQ_HOST);
      end else begin
        gnt_host_o = req_host_i;
        gnt_cim_o  = req_cim_i;
      end
      if (gnt_host_o)     last_d = REQ_HOST;
      else if (gnt_cim_o) last_d = REQ_CIM;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) last_q <= REQ_CIM;
    else     last_q <= last_d;
  end

endmodule

// File: rtl/cim_ctrl.sv
// Controller sharing one CIM array between single-word host accesses and
// multi-row accumulate jobs; every array drive signal comes from a flop.
module cim_ctrl
  import cim_pkg::*;
#(
  parameter int AWIDTH = 12,
  parameter int DWIDTH = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      h_req,
  input  logic                      h_we,
  input  logic [AWIDTH-1:0]         h_addr,
  input  logic [DWIDTH-1:0]         h_wdata,
  output logic                      h_gnt,
  output logic                      h_rvalid,
  output logic [DWIDTH-1:0]         h_rdata,
  input  logic                      c_start,
  input  logic [FUNC_W-1:0]         c_func,
  input  logic [AWIDTH-1:0]         c_base,
  input  logic [AWIDTH-1:0]         c_len,
  output logic                      c_busy,
  output logic                      c_done,
  output logic [DWIDTH+ACC_EXT-1:0] c_result,
  output logic [AWIDTH-1:0]         arr_addr,
  output logic [DWIDTH-1:0]         arr_din,
  output logic                      arr_we,
  output logic                      arr_oe,
  output logic                      arr_cme,
  output logic [FUNC_W-1:0]         arr_func,
  input  logic [DWIDTH-1:0]         arr_dout
);

  localparam int RW = DWIDTH + ACC_EXT;

  state_e state_q, state_d;
  logic   arb_en, gnt_host, gnt_cim;

  logic [FUNC_W-1:0] func_q, func_d, afunc_q, afunc_d;
  logic [AWIDTH-1:0] base_q, base_d, len_q, len_d, idx_q, idx_d;
  logic [AWIDTH-1:0] addr_q, addr_d;
  logic [DWIDTH-1:0] din_q, din_d;
  logic              we_q, we_d, oe_q, oe_d, cme_q, cme_d;
  logic              rd_pend_q, rvalid_q, rvalid_d;
  logic [RW-1:0]     acc_q, acc_d, result_q, result_d;

  assign arb_en = (state_q == S_IDLE) && !rst;

  cim_arb u_arb (
    .clk        (clk),
    .rst        (rst),
    .en_i       (arb_en),
    .req_host_i (h_req),
    .req_cim_i  (c_start),
    .gnt_host_o (gnt_host),
    .gnt_cim_o  (gnt_cim)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (gnt_host)     state_d = S_HOST;
        else if (gnt_cim) state_d = (c_len == '0) ? S_DONE : S_CIM_RUN;
      end
      S_HOST:     state_d = S_IDLE;
      S_CIM_RUN:  if (idx_q == len_q) state_d = S_CIM_WAIT;
      S_CIM_WAIT: state_d = S_DONE;
      S_DONE:     state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
  end

  always_comb begin
    h_gnt    = gnt_host;
    c_busy   = (state_q == S_CIM_RUN) || (state_q == S_CIM_WAIT);
    c_done   = (state_q == S_DONE);
    h_rvalid = rvalid_q;
    h_rdata  = rvalid_q ? arr_dout : '0;
    c_result = result_q;
    arr_addr = addr_q;
    arr_din  = din_q;
    arr_we   = we_q;
    arr_oe   = oe_q;
    arr_cme  = cme_q;
    arr_func = afunc_q;
  end

  // Array read data lands one cycle after its row was driven (rd_pend_q).
  always_comb begin
    addr_d   = '0;
    din_d    = '0;
    we_d     = 1'b0;
    oe_d     = 1'b0;
    cme_d    = 1'b0;
    afunc_d  = '0;
    func_d   = func_q;
    base_d   = base_q;
    len_d    = len_q;
    idx_d    = idx_q;
    acc_d    = rd_pend_q ? acc_q + RW'(arr_dout) : acc_q;
    result_d = result_q;
    rvalid_d = (state_q == S_HOST) && oe_q;
    case (state_q)
      S_IDLE: begin
        if (gnt_host) begin
          addr_d = h_addr;
          we_d   = h_we;
          din_d  = h_we ? h_wdata : '0;
          oe_d   = !h_we;
        end else if (gnt_cim) begin
          func_d   = c_func;
          base_d   = c_base;
          len_d    = c_len;
          idx_d    = '0;
          acc_d    = '0;
          result_d = '0;
          if (c_len != '0) begin
            addr_d  = c_base;
            cme_d   = 1'b1;
            oe_d    = 1'b1;
            afunc_d = c_func;
            idx_d   = AWIDTH'(1);
          end
        end
      end
      S_CIM_RUN: begin
        if (idx_q != len_q) begin
          addr_d  = base_q + idx_q;
          cme_d   = 1'b1;
          oe_d    = 1'b1;
          afunc_d = func_q;
          idx_d   = idx_q + AWIDTH'(1);
        end
      end
      S_CIM_WAIT: result_d = acc_d;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      func_q    <= '0;
      base_q    <= '0;
      len_q     <= '0;
      idx_q     <= '0;
      addr_q    <= '0;
      din_q     <= '0;
      we_q      <= 1'b0;
      oe_q      <= 1'b0;
      cme_q     <= 1'b0;
      afunc_q   <= '0;
      rd_pend_q <= 1'b0;
      rvalid_q  <= 1'b0;
      acc_q     <= '0;
      result_q  <= '0;
    end else begin
      func_q    <= func_d;
      base_q    <= base_d;
      len_q     <= len_d;
      idx_q     <= idx_d;
      addr_q    <= addr_d;
      din_q     <= din_d;
      we_q      <= we_d;
      oe_q      <= oe_d;
      cme_q     <= cme_d;
      afunc_q   <= afunc_d;
      rd_pend_q <= cme_q;
      rvalid_q  <= rvalid_d;
      acc_q     <= acc_d;
      result_q  <= result_d;
    end
  end

endmodule

// File: doc/cim_ctrl.md
CIM_CTRL -- requirements
Module: cim_ctrl

Interface
REQ-001 The block SHALL take parameter AWIDTH, default 12, as the array address width in bits.
REQ-002 The block SHALL take parameter DWIDTH, default 32, as the array data width in bits.
REQ-003 The block SHALL have one clock and a synchronous, active-high reset.
REQ-004 Ports SHALL be as follows (name, direction, width, meaning):
- clk in 1: clock.
- rst in 1: synchronous active-high reset.
- h_req in 1: host access request, held until granted.
- h_we in 1: host write (1) or read (0).
- h_addr in AWIDTH: host address.
- h_wdata in DWIDTH: host write data.
- h_gnt out 1: one-cycle request-accepted pulse.
- h_rvalid out 1: read data valid pulse.
- h_rdata out DWIDTH: read data.
- c_start in 1: CIM job start pulse.
- c_func in 4: CIM function code.
- c_base in AWIDTH: first row.
- c_len in AWIDTH: row count.
- c_busy out 1: job accepted and not yet done.
- c_done out 1: one-cycle job-complete pulse.
- c_result out DWIDTH+8: job accumulation.
- arr_addr out AWIDTH, arr_din out DWIDTH, arr_we out 1, arr_oe out 1, arr_cme out 1, arr_func out 4: registered array drive.
- arr_dout in DWIDTH: array read data, valid one cycle after arr_oe.

Function
REQ-005 The FSM SHALL have states IDLE, HOST, CIM_RUN, CIM_WAIT and DONE; all array drive signals SHALL be registered.
REQ-006 In IDLE, if exactly one of h_req or c_start is asserted, the block SHALL serve that requester.
REQ-007 In IDLE, if h_req and c_start are asserted together, the block SHALL grant the requester not served last (round-robin); after reset, last-served SHALL be CIM.
REQ-008 On host acceptance at cycle T:
- h_gnt SHALL be 1 at T.
- The state SHALL be HOST at T+1, with arr_addr=h_addr, plus arr_we=1 and arr_din=h_wdata for a write, or arr_oe=1 for a read.
- A read SHALL have h_rvalid=1 and h_rdata=arr_dout at T+2.
- HOST SHALL return to IDLE after one cycle.
REQ-009 On CIM acceptance, the block SHALL latch c_func, c_base and c_len, set c_busy=1 and clear the accumulator.
REQ-010 In CIM_RUN, for i = 0..len-1, the block SHALL drive one cycle per row with arr_cme=1, arr_oe=1, arr_func=latched func and arr_addr=(base+i) mod 2^AWIDTH (wrap-around permitted).
REQ-011 Each arr_dout SHALL be zero-extended and added to the accumulator one cycle after its issue cycle; CIM_WAIT SHALL last one cycle to capture the last row.
REQ-012 The accumulator SHALL be DWIDTH+8 bits and wrap modulo 2^(DWIDTH+8) on overflow.
REQ-013 In DONE, c_done SHALL be 1 for one cycle, c_result SHALL take the accumulator value and hold it until the next CIM acceptance, c_busy SHALL clear, and the next state SHALL be IDLE.
REQ-014 When c_len=0, the block SHALL go to DONE with no array access and c_result=0.
REQ-015 c_start asserted while c_busy=1 or in HOST SHALL be dropped; h_req SHALL wait until IDLE and is not dropped.
REQ-016 A CIM job SHALL NOT be pre-empted by host requests.
REQ-017 Latency for len rows from acceptance to c_done SHALL be len+2 cycles.

Reset
REQ-018 When rst=1 at a clock edge, the following SHALL occur, including mid-job:
- State returns to IDLE.
- All outputs, including c_result, are 0.
- Accumulator and latched job fields are cleared.
- Last-served is CIM.
- No c_done or h_rvalid is emitted for the aborted operation.

Structure
REQ-019 Package cim_pkg SHALL hold the FSM state enumeration, FUNC_W=4 and ACC_EXT=8.
REQ-020 Round-robin grant logic SHALL be a sub-module cim_arb (2 requesters, last-served register); everything else SHALL reside in cim_ctrl.

Verification
REQ-021 Host write 0xDEADBEEF to 0x010, then read 0x010 -> h_gnt pulses, arr_we cycle seen, h_rvalid two cycles after the read grant with h_rdata=0xDEADBEEF.
REQ-022 CIM job func=3, base=0x004, len=4, array rows holding 1,2,3,4 -> arr_cme for 4 cycles on addresses 4..7, c_done 6 cycles after start, c_result=10.
REQ-023 Wrap: base=0xFFE, len=4 -> addresses FFE, FFF, 000, 001 driven.
REQ-024 h_req and c_start asserted in the same IDLE cycle right after reset -> host granted first, CIM job runs next; repeating the collision -> CIM granted first.
REQ-025 rst asserted in the 2nd CIM_RUN cycle -> all outputs 0 next cycle, no c_done; a fresh job then completes with the correct result; c_len=0 -> c_done 1 cycle after acceptance, c_result=0.
